spio_spinnaker_link_sender: RTL and testbench

SPIO_SPINNAKER_LINK_SENDER -- requirements
Module: spio_spinnaker_link_sender

---
 rtl/spio_spinnaker_link_sender.sv | 146 ++++++++++++++
 tb/tb_spio_spinnaker_link_sender.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spio_spinnaker_link_sender.sv
`timescale 1ns/1ps
// SpiNNaker link sender: takes 72-bit packets through a one-entry holding
// buffer into a transmit shift register and sends them as NRZ 2-of-7 flits,
// one flit outstanding at a time, paced by the receiver's NRZ acknowledge.
//
// state     | meaning
// LINK_WAIT | out of reset, waiting for the first ack transition
// IDLE      | no flit outstanding (emits the next flit if a packet is loaded)
// FLIT      | flit on the wire, waiting for its ack
module spio_spinnaker_link_sender #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        tb_clk,
  input  logic        tb_rst,
  input  logic [71:0] PKT_DATA_IN,
  input  logic        PKT_VLD_IN,
  output logic        PKT_RDY_OUT,
  output logic [6:0]  SL_DATA_2OF7_OUT,
  input  logic        SL_ACK_IN
);

  localparam int         LP_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [6:0] LP_EOP    = 7'b1100000;

  typedef enum logic [1:0] {LINK_WAIT, IDLE, FLIT} state_t;

  state_t               r_state;
  logic [LP_STAGES-1:0] r_sync;
  logic                 r_last_ack;
  logic                 r_buf_full;
  logic                 r_rdy;
  logic [71:0]          r_buf_data;
  logic                 r_tx_vld;
  logic                 r_tx_long;
  logic [71:0]          r_tx_sh;
  logic [4:0]           r_flit_cnt;
  logic [6:0]           r_sl_data;

  logic                 w_ack_sync;
  logic                 w_ack_det;
  logic [4:0]           w_ndata;
  logic                 w_eop_out;
  logic [6:0]           w_sym;
  logic                 w_accept;
  logic                 w_load;
  logic                 w_buf_full_nxt;

  function automatic logic [6:0] f_code(input logic [3:0] nib);
    f_code = 7'b0000000;
    case (nib)
      4'd0:  f_code = 7'b0010001;
      4'd1:  f_code = 7'b0010010;
      4'd2:  f_code = 7'b0010100;
      4'd3:  f_code = 7'b0011000;
      4'd4:  f_code = 7'b0100001;
      4'd5:  f_code = 7'b0100010;
      4'd6:  f_code = 7'b0100100;
      4'd7:  f_code = 7'b0101000;
      4'd8:  f_code = 7'b1000001;
      4'd9:  f_code = 7'b1000010;
      4'd10: f_code = 7'b1000100;
      4'd11: f_code = 7'b1001000;
      4'd12: f_code = 7'b0000011;
      4'd13: f_code = 7'b0000110;
      4'd14: f_code = 7'b0001100;
      4'd15: f_code = 7'b0001001;
    endcase
  endfunction

  assign PKT_RDY_OUT      = r_rdy;
  assign SL_DATA_2OF7_OUT = r_sl_data;

  // Ack edge detection, flit selection and holding-buffer hand-off decisions.
  always_comb begin
    w_ack_sync = r_sync[LP_STAGES-1];
    w_ack_det  = w_ack_sync ^ r_last_ack;
    w_ndata    = r_tx_long ? 5'd18 : 5'd10;
    // Counter has already stepped past the EOP once EOP is on the wire.
    w_eop_out  = (r_flit_cnt == (w_ndata + 5'd1));
    w_sym      = (r_flit_cnt == w_ndata) ? LP_EOP : f_code(r_tx_sh[3:0]);
    w_accept   = PKT_VLD_IN & r_rdy;
    w_load     = r_buf_full &
                 (((r_state == IDLE) & ~r_tx_vld) |
                  ((r_state == FLIT) & w_ack_det & w_eop_out));
    w_buf_full_nxt = w_accept | (r_buf_full & ~w_load);
  end

  // Acknowledge synchroniser chain.
  always_ff @(posedge tb_clk or posedge tb_rst) begin
    if (tb_rst) r_sync <= '0;
    else        r_sync <= {r_sync[LP_STAGES-2:0], SL_ACK_IN};
  end

  // Link FSM with holding buffer, transmit shift register and wire state.
  always_ff @(posedge tb_clk or posedge tb_rst) begin
    if (tb_rst) begin
      r_state    <= LINK_WAIT;
      r_last_ack <= 1'b0;
      r_buf_full <= 1'b0;
      r_rdy      <= 1'b0;
      r_buf_data <= '0;
      r_tx_vld   <= 1'b0;
      r_tx_long  <= 1'b0;
      r_tx_sh    <= '0;
      r_flit_cnt <= '0;
      r_sl_data  <= '0;
    end else begin
      if (w_ack_det) r_last_ack <= w_ack_sync;

      case (r_state)
        LINK_WAIT: begin
          if (w_ack_det) r_state <= IDLE;
        end
        IDLE: begin
          if (r_tx_vld) begin
            r_sl_data  <= r_sl_data ^ w_sym;
            r_flit_cnt <= r_flit_cnt + 5'd1;
            r_tx_sh    <= {4'h0, r_tx_sh[71:4]};
            r_state    <= FLIT;
          end
        end
        FLIT: begin
          if (w_ack_det) begin
            r_state <= IDLE;
            if (w_eop_out) r_tx_vld <= 1'b0;
          end
        end
        default: r_state <= LINK_WAIT;
      endcase

      // Load overrides the end-of-packet clear so back-to-back packets
      // continue without an idle cycle.
      if (w_load) begin
        r_tx_sh    <= r_buf_data;
        r_tx_long  <= r_buf_data[1];
        r_tx_vld   <= 1'b1;
        r_flit_cnt <= '0;
      end

      if (w_accept) r_buf_data <= PKT_DATA_IN;
      r_buf_full <= w_buf_full_nxt;
      r_rdy      <= ~w_buf_full_nxt;
    end
  end

endmodule

// File: tb/tb_spio_spinnaker_link_sender.sv
`timescale 1ns/1ps
// Self-checking bench for spio_spinnaker_link_sender: a packet driver, a link
// responder that decodes every wire transition against a packet-level model,
// and a main sequence of directed and randomized scenarios.
module tb_spio_spinnaker_link_sender;

  localparam int S = 2;

  logic        tb_clk;
  logic        tb_rst;
  logic [71:0] PKT_DATA_IN;
  logic        PKT_VLD_IN;
  logic        PKT_RDY_OUT;
  logic [6:0]  SL_DATA_2OF7_OUT;
  logic        SL_ACK_IN;

  spio_spinnaker_link_sender #(.SYNC_STAGES(S)) dut (
    .tb_clk           (tb_clk),
    .tb_rst           (tb_rst),
    .PKT_DATA_IN      (PKT_DATA_IN),
    .PKT_VLD_IN       (PKT_VLD_IN),
    .PKT_RDY_OUT      (PKT_RDY_OUT),
    .SL_DATA_2OF7_OUT (SL_DATA_2OF7_OUT),
    .SL_ACK_IN        (SL_ACK_IN)
  );

  typedef struct {
    logic [6:0] sym;
    bit         first;
    bit         eop;
    int         xfer;
  } flit_t;

  logic [6:0] sym_tab [16] = '{7'b0010001, 7'b0010010, 7'b0010100, 7'b0011000,
                               7'b0100001, 7'b0100010, 7'b0100100, 7'b0101000,
                               7'b1000001, 7'b1000010, 7'b1000100, 7'b1001000,
                               7'b0000011, 7'b0000110, 7'b0001100, 7'b0001001};
  logic [6:0] short_exp [11] = '{7'b0010001, 7'b0000000, 7'b0010010, 7'b0000011,
                                 7'b0010010, 7'b0000011, 7'b0010010, 7'b0000011,
                                 7'b0010010, 7'b0000011, 7'b1100011};

  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  logic [71:0] send_q [$];
  flit_t       exp_q [$];
  logic [6:0]  wire_log [$];
  int          drv_idx  = 0;
  int          mon_idx  = 0;
  int          eop_seen = 0;
  int          man_req  = 0;
  bit          man_link = 0;
  bit          stall    = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  initial begin
    tb_clk = 1'b0;
    forever #5 tb_clk = ~tb_clk;
  end

  initial forever begin
    @(posedge tb_clk);
    cyc++;
  end

  // Packet driver: presents queued packets, records each transfer and the
  // flit symbols it must produce.
  initial begin
    bit          pv, pr;
    logic [71:0] d;
    flit_t       f;
    int          ndat;
    pv = 0; pr = 0;
    PKT_VLD_IN  = 1'b0;
    PKT_DATA_IN = '0;
    forever begin
      @(negedge tb_clk);
      if (tb_rst) begin
        PKT_VLD_IN = 1'b0;
        drv_idx = send_q.size();
        pv = 0; pr = 0;
      end else begin
        if (pv && pr) begin
          d    = PKT_DATA_IN;
          ndat = d[1] ? 18 : 10;
          for (int i = 0; i < ndat; i++) begin
            f.sym = sym_tab[d[4*i +: 4]]; f.first = (i == 0); f.eop = 0; f.xfer = cyc;
            exp_q.push_back(f);
          end
          f.sym = 7'b1100000; f.first = 0; f.eop = 1; f.xfer = cyc;
          exp_q.push_back(f);
          PKT_VLD_IN = 1'b0;
          drv_idx++;
        end
        if (!PKT_VLD_IN && drv_idx < send_q.size()) begin
          PKT_DATA_IN = send_q[drv_idx];
          PKT_VLD_IN  = 1'b1;
        end
        pv = PKT_VLD_IN;
        pr = PKT_RDY_OUT;
      end
    end
  end

  // Link responder: decodes each wire toggle, checks symbol and timing,
  // and returns an ack toggle after a random delay unless stalled.
  initial begin
    logic [6:0] prev_w, cur;
    flit_t      e;
    int         ack_cd, free_cyc, last_det, want, man_done;
    bit         owe, out_eop;
    prev_w = '0; ack_cd = 0; free_cyc = 1 << 30; last_det = 0; man_done = 0;
    owe = 0; out_eop = 0;
    SL_ACK_IN = 1'b0;
    forever begin
      @(negedge tb_clk);
      cur = SL_DATA_2OF7_OUT;
      if (tb_rst) begin
        prev_w = '0; mon_idx = exp_q.size(); ack_cd = 0; owe = 0; out_eop = 0;
        SL_ACK_IN = 1'b0; free_cyc = 1 << 30; man_done = man_req;
      end else begin
        if (cur !== prev_w) begin
          wire_log.push_back(cur);
          if (mon_idx >= exp_q.size()) begin
            check_val("spurious_flit", 64'(cur ^ prev_w), 64'd0);
          end else begin
            e = exp_q[mon_idx];
            mon_idx++;
            check_val("flit_sym", 64'(cur ^ prev_w), 64'(e.sym));
            // A packet may start once the transmitter frees up and one edge
            // after it was loaded; later flits one edge after ack detection.
            want = e.first ? (((free_cyc > e.xfer + 1) ? free_cyc : e.xfer + 1) + 1)
                           : last_det + 1;
            check_val("flit_lat", 64'(cyc), 64'(want));
            out_eop = e.eop;
            if (e.eop) eop_seen++;
          end
          owe    = 1;
          prev_w = cur;
        end
        if (man_done != man_req) begin
          man_done  = man_req;
          SL_ACK_IN = ~SL_ACK_IN;
          last_det  = cyc + S + 1;
          if (man_link) free_cyc = cyc + S + 2;
        end else if (!stall && owe && ack_cd == 0) begin
          ack_cd = $urandom_range(1, 3);
          owe    = 0;
        end
        if (ack_cd > 0) begin
          ack_cd--;
          if (ack_cd == 0) begin
            SL_ACK_IN = ~SL_ACK_IN;
            last_det  = cyc + S + 1;
            if (out_eop) free_cyc = last_det;
            out_eop = 0;
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge tb_clk);
  endtask

  task automatic push_pkt(input logic [71:0] d);
    send_q.push_back(d);
  endtask

  function automatic logic [71:0] rand_pkt(input bit long_pkt);
    logic [71:0] d;
    d[31:0]  = $urandom;
    d[63:32] = $urandom;
    d[71:64] = 8'($urandom);
    d[1]     = long_pkt;
    return d;
  endfunction

  task automatic link_up();
    man_link = 1;
    man_req++;
  endtask

  task automatic spur_ack();
    man_link = 0;
    man_req++;
  endtask

  task automatic drain();
    for (int k = 0; k < 6000; k++) begin
      if (drv_idx == send_q.size() && mon_idx == exp_q.size()) break;
      @(negedge tb_clk);
    end
    cycles(12);
    check_val("drain_sent", 64'(drv_idx), 64'(send_q.size()));
    check_val("drain_flits", 64'(mon_idx), 64'(exp_q.size()));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int         base, e0, m0, l0, gap;
    logic [6:0] held;
    tb_rst = 1'b1;
    cycles(3);
    check_val("rst_wire", 64'(SL_DATA_2OF7_OUT), 64'd0);
    check_val("rst_rdy", 64'(PKT_RDY_OUT), 64'd0);
    #2 tb_rst = 1'b0;
    @(negedge tb_clk);
    check_val("rdy_after_release", 64'(PKT_RDY_OUT), 64'd1);

    // Short packet presented before the link is up.
    push_pkt({32'hDEADBEEF, 32'h00000001, 8'h00});
    cycles(20);
    check_val("no_flit_prelink", 64'(SL_DATA_2OF7_OUT), 64'd0);
    check_val("buffered_rdy_low", 64'(PKT_RDY_OUT), 64'd0);
    base = wire_log.size();
    link_up();
    drain();
    for (int i = 0; i < 11; i++)
      check_val("short_wire", 64'((base + i < wire_log.size()) ? wire_log[base + i] : 7'h7f),
                64'(short_exp[i]));

    // Long packet with alternating payload nibbles.
    push_pkt({32'hA5A5A5A5, 32'h12345678, 8'h02});
    drain();

    // Back-to-back pair.
    e0 = eop_seen;
    push_pkt(rand_pkt(0));
    push_pkt(rand_pkt(1));
    for (int k = 0; k < 200 && drv_idx != send_q.size(); k++) @(negedge tb_clk);
    check_val("b2b_accepted", 64'(drv_idx), 64'(send_q.size()));
    check_val("b2b_rdy_low", 64'(PKT_RDY_OUT), 64'd0);
    check_val("b2b_first_busy", 64'(eop_seen), 64'(e0));
    drain();

    // Ack stall.
    stall = 1;
    m0 = mon_idx;
    push_pkt(rand_pkt(1'($urandom_range(0, 1))));
    for (int k = 0; k < 100 && mon_idx == m0; k++) @(negedge tb_clk);
    check_val("stall_first_flit", 64'(mon_idx), 64'(m0 + 1));
    held = SL_DATA_2OF7_OUT;
    cycles(1000);
    check_val("stall_wire_hold", 64'(SL_DATA_2OF7_OUT), 64'(held));
    check_val("stall_no_flit", 64'(mon_idx), 64'(m0 + 1));
    stall = 0;
    drain();

    // Ack toggle while idle.
    cycles(5);
    held = SL_DATA_2OF7_OUT;
    l0   = wire_log.size();
    spur_ack();
    cycles(15);
    check_val("idle_ack_wire", 64'(SL_DATA_2OF7_OUT), 64'(held));
    check_val("idle_ack_nolog", 64'(wire_log.size()), 64'(l0));
    push_pkt(rand_pkt(0));
    drain();

    // Randomized traffic with random gaps.
    for (int p = 0; p < 16; p++) begin
      push_pkt(rand_pkt(1'($urandom_range(0, 1))));
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60);
      cycles(gap);
    end
    drain();

    // Reset mid-packet with a second packet buffered.
    m0 = mon_idx;
    push_pkt(rand_pkt(1));
    push_pkt(rand_pkt(0));
    for (int k = 0; k < 200 && mon_idx < m0 + 3; k++) @(negedge tb_clk);
    @(negedge tb_clk);
    #2 tb_rst = 1'b1;
    #1;
    check_val("midrst_wire", 64'(SL_DATA_2OF7_OUT), 64'd0);
    check_val("midrst_rdy", 64'(PKT_RDY_OUT), 64'd0);
    cycles(3);
    @(negedge tb_clk);
    #2 tb_rst = 1'b0;
    @(negedge tb_clk);
    check_val("midrst_rdy_release", 64'(PKT_RDY_OUT), 64'd1);
    l0 = wire_log.size();
    cycles(20);
    check_val("midrst_no_resume", 64'(SL_DATA_2OF7_OUT), 64'd0);
    check_val("midrst_nolog", 64'(wire_log.size()), 64'(l0));
    push_pkt(rand_pkt(1));
    cycles(10);
    check_val("midrst_linkwait", 64'(SL_DATA_2OF7_OUT), 64'd0);
    link_up();
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
